mux4_rr_arbiter: RTL
====================

// Module: mux4_rr_arbiter
// PURPOSE
//  Round-robin arbiter sharing one DATA_WIDTH-wide 4:1 mux datapath between four
//  valid/ready requesters. Grants one requester per burst, drives the mux select,
//  and routes the handshake between the granted requester and a single downstream
//  sink. Sits between bus masters (fetch, LSU, debug, DMA) and a shared target port.
// PARAMETERS
//  DATA_WIDTH  64  width of each requester data bus and of out_data
//  MAX_BURST   4   max beats per grant before forced release (>=1; CNT_W=$clog2(MAX_BURST+1))
// PORTS
//  clk        in   1             clock, all state on rising edge
//  rst        in   1             synchronous reset, active-high
//  req_valid  in   4             requester n has a beat pending (bit n)
//  req_last   in   4             requester n's current beat ends its burst
//  req_data0  in   DATA_WIDTH    requester 0 data (req_data1..3 identical)
//  req_ready  out  4             beat accepted from requester n
//  out_valid  out  1             beat presented downstream
//  out_data   out  DATA_WIDTH    mux4 output of granted requester
//  out_last   out  1             req_last of granted requester
//  out_ready  in   1             downstream accepts beat
//  sel        out  2             mux4 select = granted index
//  busy       out  1             grant held (state BUSY)
// BEHAVIOUR
//  - Clock clk, reset rst: one clock; reset synchronous, active-high.
//  - Reset: state=IDLE, sel=0, ptr=0, beat_cnt=0, busy=0; out_valid=0, req_ready=0.
//  - State IDLE: if |req_valid, winner = first n in order ptr,ptr+1,..,ptr+3 (mod 4)
//    with req_valid[n]=1; next cycle state=BUSY, sel=winner, beat_cnt=0. Else stay.
//    Arbitration latency: 1 cycle from req_valid to out_valid. No beat passes in IDLE.
//  - State BUSY (combinational outputs): out_valid=req_valid[sel]; out_data=req_data[sel];
//    out_last=req_last[sel]; req_ready[sel]=out_ready; req_ready[others]=0.
//  - Beat = out_valid & out_ready in BUSY; beat_cnt increments by 1 per beat.
//  - Release on beat with out_last=1 OR beat_cnt==MAX_BURST-1 (MAX_BURSTth beat):
//    next cycle state=IDLE, ptr=sel+1 (mod 4, 3 wraps to 0), beat_cnt=0, busy=0.
//  - One IDLE bubble cycle after every release; sel holds last value in IDLE.
//  - Granted requester dropping req_valid mid-burst: out_valid=0, grant held, no timeout.
//  - Changes on non-granted req_valid/req_data while BUSY: no effect on outputs.
//  - out_ready low: no beat, beat_cnt and state hold; data must be held by requester.
//  - rst asserted in BUSY: no beat counted that cycle; next cycle IDLE, ptr=0.
//  - MAX_BURST=1: every beat releases; req_last ignored for release.
//  - Grant only changes on release; never preempted except by rst.
// TESTING
//  1 Reset: rst=1 two cycles, all req_valid=1 -> out_valid=0, req_ready=0, sel=0,
//    busy=0 while rst=1; first grant after release of rst goes to requester 0.
//  2 Single requester: req_valid=4'b0100, req_data2=64'h2, req_last[2]=1, out_ready=1
//    -> cycle+1: busy=1, sel=2, out_data=64'h2, req_ready=4'b0100; cycle+2 busy=0.
//  3 Round robin: req_valid=4'b1111, req_dataN=64'hN, all req_last=1, out_ready=1
//    -> grants sel=0,1,2,3,0 with one idle cycle between; out_data 0,1,2,3,0.
//  4 Burst cap: MAX_BURST=4, req_valid=4'b0011, req_last=0, out_ready=1 -> requester 0
//    gets exactly 4 beats, then idle cycle, then sel=1.
//  5 Backpressure: granted sel=1, out_ready=0 for 3 cycles -> req_ready=0, out_valid=1,
//    out_data stable, beat_cnt unchanged; out_ready=1 -> beat accepted.
//  6 Reset mid-burst: rst=1 after 2 of 4 beats -> next cycle busy=0, ptr=0, out_valid=0;
//    with req_valid=4'b1010 afterwards, first grant is sel=1.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mux4_rr_arbiter
//   Round-robin arbiter in front of a shared DATA_WIDTH-wide 4:1 mux. One
//   requester is granted per burst; while the grant is held the valid/ready
//   handshake is routed straight through between that requester and the
//   single downstream sink. A grant ends on a beat carrying last, or on the
//   MAX_BURST-th beat, followed by one idle arbitration cycle.
//
// Ports
//   clk        : clock, all state on the rising edge
//   rst        : synchronous reset, active-high
//   req_valid  : per-requester beat pending (bit n = requester n)
//   req_last   : per-requester "this beat ends the burst"
//   req_data0-3: per-requester data
//   req_ready  : per-requester beat accepted
//   out_valid  : beat presented downstream
//   out_data   : mux output of the granted requester
//   out_last   : req_last of the granted requester
//   out_ready  : downstream accepts the beat
//   sel        : mux select, equal to the granted requester index
//   busy       : a grant is being held
// ---------------------------------------------------------------------------
module mux4_rr_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            req_valid,
    input  logic [3:0]            req_last,
    input  logic [DATA_WIDTH-1:0] req_data0,
    input  logic [DATA_WIDTH-1:0] req_data1,
    input  logic [DATA_WIDTH-1:0] req_data2,
    input  logic [DATA_WIDTH-1:0] req_data3,
    output logic [3:0]            req_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready,
    output logic [1:0]            sel,
    output logic                  busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_reg;
    logic [1:0]        sel_reg;
    logic [1:0]        ptr_reg;
    logic [CNT_W-1:0]  beat_cnt_reg;

    logic [DATA_WIDTH-1:0] data_arr [4];
    logic [3:0]            rot_valid;
    logic [1:0]            offset;
    logic [1:0]            winner;
    logic                  beat;
    logic                  release_now;

    assign data_arr[0] = req_data0;
    assign data_arr[1] = req_data1;
    assign data_arr[2] = req_data2;
    assign data_arr[3] = req_data3;

    // rot_valid[k] is the request k positions after the round-robin pointer,
    // so the lowest set bit is the next requester in fair order.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign rot_valid[gi] = req_valid[2'(ptr_reg + 2'(gi))];
        end
    endgenerate

    always_comb begin
        offset = 2'd0;
        if (rot_valid[0])      offset = 2'd0;
        else if (rot_valid[1]) offset = 2'd1;
        else if (rot_valid[2]) offset = 2'd2;
        else if (rot_valid[3]) offset = 2'd3;
    end

    assign winner = 2'(ptr_reg + offset);

    // Handshake routing. Gating with rst keeps everything quiet during reset,
    // including the very first reset cycle before the state is known.
    assign busy      = (state_reg == BUSY);
    assign sel       = sel_reg;
    assign out_valid = busy & ~rst & req_valid[sel_reg];
    assign out_data  = data_arr[sel_reg];
    assign out_last  = req_last[sel_reg];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ready
            assign req_ready[gi] = busy & ~rst & out_ready & (sel_reg == 2'(gi));
        end
    endgenerate

    assign beat        = out_valid & out_ready;
    // The burst cap also covers MAX_BURST=1, where every beat releases.
    assign release_now = out_last | (beat_cnt_reg == CNT_W'(MAX_BURST - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            sel_reg      <= 2'd0;
            ptr_reg      <= 2'd0;
            beat_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|req_valid) begin
                        state_reg    <= BUSY;
                        sel_reg      <= winner;
                        beat_cnt_reg <= '0;
                    end
                end
                BUSY: begin
                    if (beat) begin
                        if (release_now) begin
                            state_reg    <= IDLE;
                            ptr_reg      <= 2'(sel_reg + 2'd1);
                            beat_cnt_reg <= '0;
                        end else begin
                            beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule
